// File: rtl/faultpipe_if.sv
// Control/status bundle of the fault pipeline: stall/flush/fault inputs in,
// last-stage vector plus capture/counter status out.
interface faultpipe_if #(
  parameter int NSTAGES = 3,
  parameter int NFAULT  = 4,
  parameter int CNTW    = 8
);
  localparam int IW = $clog2(NFAULT);

  logic [NSTAGES-1:0]        Stall;
  logic [NSTAGES-1:0]        Flush;
  logic                      StallOut;
  logic [NSTAGES*NFAULT-1:0] FaultIn;
  logic                      FaultAck;
  logic [NFAULT-1:0]         FaultVecOut;
  logic                      FaultValid;
  logic [IW-1:0]             FaultIdx;
  logic                      CapValid;
  logic [IW-1:0]             CapIdx;
  logic                      CapOverflow;
  logic [CNTW-1:0]           FaultCount;

  modport master (
    output Stall, Flush, StallOut, FaultIn, FaultAck,
    input  FaultVecOut, FaultValid, FaultIdx, CapValid, CapIdx, CapOverflow, FaultCount
  );

  modport slave (
    input  Stall, Flush, StallOut, FaultIn, FaultAck,
    output FaultVecOut, FaultValid, FaultIdx, CapValid, CapIdx, CapOverflow, FaultCount
  );
endinterface

// File: rtl/faultpipe.sv
// Fault vectors ride a stall/flush-controlled pipe; the last stage is priority
// encoded and retired faults feed a sticky first-fault capture and a counter.
module faultpipe #(
  parameter int NSTAGES = 3,
  parameter int NFAULT  = 4,
  parameter int CNTW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  faultpipe_if.slave  bus
);
   localparam int IW = $clog2(NFAULT);

   logic [NSTAGES:1][NFAULT-1:0] stage_q, stage_d;
   logic [NSTAGES:0][NFAULT-1:0] chain;
   logic                         cap_valid_q, cap_valid_d;
   logic [IW-1:0]                cap_idx_q, cap_idx_d;
   logic                         cap_ovf_q, cap_ovf_d;
   logic [CNTW-1:0]              fault_count_q, fault_count_d;
   logic [NFAULT-1:0]            last_vec;
   logic                         fault_valid;
   logic [IW-1:0]                fault_idx;
   logic                         retire;

   // NOTE: every variable gets a default before any branch, so no latch is inferred.
   always_comb begin
      chain    = '0;
      stage_d  = stage_q;
      for (int s = 1; s <= NSTAGES; s++) begin
         chain[s] = stage_q[s];
      end
      // Stall wins over flush: a stalled stage ignores its flush request.
      for (int s = 1; s <= NSTAGES; s++) begin
         if (!bus.Stall[s-1]) begin
            if (bus.Flush[s-1]) stage_d[s] = '0;
            else stage_d[s] = chain[s-1] | bus.FaultIn[(s-1)*NFAULT +: NFAULT];
         end
      end
   end

   always_comb begin
      last_vec    = stage_q[NSTAGES];
      fault_valid = |last_vec;
      fault_idx   = '0;
      for (int i = NFAULT - 1; i >= 0; i--) begin
         if (last_vec[i]) fault_idx = i[IW-1:0];
      end
   end

   assign retire = fault_valid & ~bus.StallOut;

   always_comb begin
      cap_valid_d   = cap_valid_q;
      cap_idx_d     = cap_idx_q;
      cap_ovf_d     = cap_ovf_q;
      fault_count_d = fault_count_q;
      if (retire) begin
         // An ack arriving with a new fault frees the slot for that fault.
         if (!cap_valid_q || bus.FaultAck) begin
            cap_valid_d = 1'b1;
            cap_idx_d   = fault_idx;
            cap_ovf_d   = 1'b0;
         end else begin
            cap_ovf_d   = 1'b1;
         end
         if (fault_count_q != {CNTW{1'b1}}) fault_count_d = fault_count_q + CNTW'(1);
      end else if (bus.FaultAck) begin
         cap_valid_d = 1'b0;
         cap_ovf_d   = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample together.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q       <= '0;
         cap_valid_q   <= 1'b0;
         cap_idx_q     <= '0;
         cap_ovf_q     <= 1'b0;
         fault_count_q <= '0;
      end else begin
         stage_q       <= stage_d;
         cap_valid_q   <= cap_valid_d;
         cap_idx_q     <= cap_idx_d;
         cap_ovf_q     <= cap_ovf_d;
         fault_count_q <= fault_count_d;
      end
   end

   assign bus.FaultVecOut = last_vec;
   assign bus.FaultValid  = fault_valid;
   assign bus.FaultIdx    = fault_idx;
   assign bus.CapValid    = cap_valid_q;
   assign bus.CapIdx      = cap_idx_q;
   assign bus.CapOverflow = cap_ovf_q;
   assign bus.FaultCount  = fault_count_q;
endmodule

// File: tb/tb_faultpipe.sv
// Directed bench for faultpipe: a cycle model checked every negedge plus
// hand-computed literal expectations at key points of each scenario.
module tb_faultpipe;
   localparam int NS  = 3;
   localparam int NF  = 4;
   localparam int CW  = 8;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   faultpipe_if #(.NSTAGES(NS), .NFAULT(NF), .CNTW(CW)) bus ();
   faultpipe #(.NSTAGES(NS), .NFAULT(NF), .CNTW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [NF-1:0] v);
      for (int i = 0; i < NF; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Reference model: fault vectors per instruction slot, capture and count.
   logic [NF-1:0] m_stage [0:NS];
   bit            m_cap_valid = 0;
   int            m_cap_idx   = 0;
   bit            m_cap_ovf   = 0;
   int            m_count     = 0;

   initial for (int s = 0; s <= NS; s++) m_stage[s] = '0;

   always @(posedge clk) begin
      automatic logic [NF-1:0] nxt [1:NS];
      automatic bit r = (m_stage[NS] != '0) && !bus.StallOut;
      if (reset) begin
         for (int s = 1; s <= NS; s++) m_stage[s] <= '0;
         m_cap_valid <= 0; m_cap_idx <= 0; m_cap_ovf <= 0; m_count <= 0;
      end else begin
         for (int s = 1; s <= NS; s++) begin
            if (bus.Stall[s-1])      nxt[s] = m_stage[s];
            else if (bus.Flush[s-1]) nxt[s] = '0;
            else                     nxt[s] = m_stage[s-1] | bus.FaultIn[(s-1)*NF +: NF];
         end
         for (int s = 1; s <= NS; s++) m_stage[s] <= nxt[s];
         if (r) begin
            if (!m_cap_valid || bus.FaultAck) begin
               m_cap_valid <= 1; m_cap_idx <= lowest(m_stage[NS]); m_cap_ovf <= 0;
            end else m_cap_ovf <= 1;
            m_count <= (m_count < MAXC) ? m_count + 1 : MAXC;
         end else if (bus.FaultAck) begin
            m_cap_valid <= 0; m_cap_ovf <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_vec",   32'(bus.FaultVecOut), 32'(m_stage[NS]));
         check("m_valid", 32'(bus.FaultValid),  32'(m_stage[NS] != '0));
         check("m_idx",   32'(bus.FaultIdx),    32'(lowest(m_stage[NS])));
         check("m_capv",  32'(bus.CapValid),    32'(m_cap_valid));
         check("m_capi",  32'(bus.CapIdx),      32'(m_cap_idx));
         check("m_ovf",   32'(bus.CapOverflow), 32'(m_cap_ovf));
         check("m_cnt",   32'(bus.FaultCount),  32'(m_count));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      bus.Stall = '0; bus.Flush = '0; bus.StallOut = 1'b0;
      bus.FaultIn = '0; bus.FaultAck = 1'b0;
      cyc(2);
      cmp_en = 1'b1;
      reset  = 1'b0;
      check("rst_vec",  32'(bus.FaultVecOut), 0);
      check("rst_capv", 32'(bus.CapValid),    0);
      check("rst_cnt",  32'(bus.FaultCount),  0);

      // Slice 0 fault reaches the last stage three edges later.
      bus.FaultIn = 12'h004;
      cyc(1); bus.FaultIn = '0;
      check("lat_e1", 32'(bus.FaultVecOut), 0);
      cyc(1);
      check("lat_e2", 32'(bus.FaultVecOut), 0);
      cyc(1);
      check("lat_vec", 32'(bus.FaultVecOut), 32'h4);
      check("lat_idx", 32'(bus.FaultIdx),    2);
      cyc(1);
      check("cap1_v",   32'(bus.CapValid),   1);
      check("cap1_i",   32'(bus.CapIdx),     2);
      check("cap1_cnt", 32'(bus.FaultCount), 1);

      // Faults from two stages OR into the same instruction.
      bus.FaultIn = 12'h004; cyc(1);
      bus.FaultIn = 12'h010; cyc(1);
      bus.FaultIn = '0;      cyc(1);
      check("or_vec", 32'(bus.FaultVecOut), 32'h5);
      check("or_idx", 32'(bus.FaultIdx),    0);
      cyc(1);
      check("or_capi", 32'(bus.CapIdx),      2);
      check("or_ovf",  32'(bus.CapOverflow), 1);
      check("or_cnt",  32'(bus.FaultCount),  2);

      bus.FaultAck = 1'b1; cyc(1); bus.FaultAck = 1'b0;
      check("ack0_v",   32'(bus.CapValid),    0);
      check("ack0_ovf", 32'(bus.CapOverflow), 0);

      // Stall beats flush; a later unstalled flush kills the fault.
      bus.FaultIn = 12'h002; cyc(1);
      bus.FaultIn = '0;      cyc(1);
      bus.Stall = 3'b110; bus.Flush = 3'b010;
      cyc(2);
      check("stl_hold", 32'(dut.stage_q[2]), 32'h2);
      check("stl_vec",  32'(bus.FaultVecOut), 0);
      bus.Stall = 3'b100;
      cyc(1);
      check("fl_clr", 32'(dut.stage_q[2]), 0);
      bus.Stall = '0; bus.Flush = '0;
      cyc(3);
      check("fl_cnt", 32'(bus.FaultCount),  2);
      check("fl_vec", 32'(bus.FaultVecOut), 0);

      // Sticky first fault, overflow, ack, and ack colliding with retire.
      bus.FaultIn = 12'h800; cyc(1); bus.FaultIn = '0;
      check("s_idx3", 32'(bus.FaultIdx), 3);
      cyc(1);
      check("s_capi3", 32'(bus.CapIdx), 3);
      bus.FaultIn = 12'h200; cyc(1); bus.FaultIn = '0;
      cyc(1);
      check("s_keep", 32'(bus.CapIdx),      3);
      check("s_ovf",  32'(bus.CapOverflow), 1);
      check("s_cnt",  32'(bus.FaultCount),  4);
      bus.FaultAck = 1'b1; cyc(1); bus.FaultAck = 1'b0;
      check("a_v",   32'(bus.CapValid),    0);
      check("a_ovf", 32'(bus.CapOverflow), 0);
      bus.FaultIn = 12'h200; cyc(1); bus.FaultIn = '0;
      bus.FaultAck = 1'b1; cyc(1); bus.FaultAck = 1'b0;
      check("ar_v", 32'(bus.CapValid), 1);
      check("ar_i", 32'(bus.CapIdx),   1);
      bus.FaultIn = 12'h800; cyc(1); bus.FaultIn = '0;
      bus.FaultAck = 1'b1; cyc(1); bus.FaultAck = 1'b0;
      check("ar2_i",   32'(bus.CapIdx),      3);
      check("ar2_ovf", 32'(bus.CapOverflow), 0);
      check("ar2_cnt", 32'(bus.FaultCount),  6);

      // StallOut blocks retirement; then saturate the counter.
      bus.FaultIn = 12'h400; cyc(1); bus.FaultIn = '0;
      bus.StallOut = 1'b1; bus.Stall = 3'b100;
      cyc(5);
      check("so_cnt",  32'(bus.FaultCount),  6);
      check("so_capi", 32'(bus.CapIdx),      3);
      check("so_vec",  32'(bus.FaultVecOut), 32'h4);
      bus.StallOut = 1'b0; bus.Stall = '0;
      cyc(1);
      check("so_rel", 32'(bus.FaultCount), 7);
      bus.FaultIn = 12'h100; cyc(1); bus.FaultIn = '0;
      bus.Stall = 3'b100;
      cyc(248);
      check("sat_255", 32'(bus.FaultCount), 255);
      cyc(3);
      check("sat_hold", 32'(bus.FaultCount), 255);
      bus.Stall = '0;

      // Reset mid-stream with every stage loaded and a capture held.
      bus.FaultIn = 12'h421;
      cyc(3);
      check("pre_capv", 32'(bus.CapValid), 1);
      reset = 1'b1; bus.Stall = 3'b111;
      cyc(1);
      check("mr_vec",  32'(bus.FaultVecOut), 0);
      check("mr_capv", 32'(bus.CapValid),    0);
      check("mr_capi", 32'(bus.CapIdx),      0);
      check("mr_ovf",  32'(bus.CapOverflow), 0);
      check("mr_cnt",  32'(bus.FaultCount),  0);
      reset = 1'b0; bus.Stall = '0; bus.FaultIn = '0;
      cyc(4);
      check("post_vec", 32'(bus.FaultVecOut), 0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
